if_id_skid_reg: RTL and testbench

- Parametrised successor to the fetch/decode pipeline register.
- Carries an instruction word and its PC+4 from the fetch stage to the decode stage using a valid/ready handshake instead of a bare enable.
- A 2-entry skid buffer lets fetch see a registered ready. Downstream back-pressure therefore never creates a combinational path to fetch.
- Adds a flush input for branch/jump squash and a configurable reset PC.

---
 rtl/if_id_skid_reg.sv | 187 ++++++++++++++++++
 tb/tb_if_id_skid_reg.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_skid_reg.sv
// -----------------------------------------------------------------------------
// if_id_skid_reg
//
// Fetch-to-decode pipeline register with a valid/ready handshake. A two-entry
// skid buffer (main + skid) makes in_ready a function of registered state
// only. Decode back-pressure therefore never reaches fetch combinationally.
//
// Parameters:
//   IR_W      instruction word width
//   PC_W      PC+4 field width
//   RESET_PC4 value of out_pc4 after reset (truncated to PC_W)
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset (priority over flush)
//   flush      squash held and incoming beats this cycle
//   in_valid   fetch presents a beat
//   in_ready   block can accept a beat (registered state only, low in reset)
//   in_ir      instruction from fetch
//   in_pc4     PC+4 from fetch
//   out_valid  decode-side beat valid
//   out_ready  decode consumes the beat
//   out_ir     instruction to decode
//   out_pc4    PC+4 to decode
//   stall_cnt  saturating count of cycles with out_valid && !out_ready
//
// Build option:
//   IF_ID_STALL_CNT_EN  when defined, stall_cnt is a live counter; otherwise
//                       it is tied to zero. The port list is the same in both
//                       builds.
// -----------------------------------------------------------------------------
module if_id_skid_reg #(
    parameter int unsigned IR_W      = 32,
    parameter int unsigned PC_W      = 32,
    parameter logic [31:0] RESET_PC4 = 32'h0000_0004
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IR_W-1:0] in_ir,
    input  logic [PC_W-1:0] in_pc4,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [IR_W-1:0] out_ir,
    output logic [PC_W-1:0] out_pc4,
    output logic [15:0]     stall_cnt
);

    localparam logic [PC_W-1:0] RESET_PC4_T = PC_W'(RESET_PC4);

    // The state is the pair {m_valid, s_valid}; 2'b01 cannot be reached.
    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b10;
    localparam logic [1:0] ST_TWO   = 2'b11;

    logic            m_valid_q, m_valid_d;
    logic [IR_W-1:0] m_ir_q,    m_ir_d;
    logic [PC_W-1:0] m_pc4_q,   m_pc4_d;
    logic            s_valid_q, s_valid_d;
    logic [IR_W-1:0] s_ir_q,    s_ir_d;
    logic [PC_W-1:0] s_pc4_q,   s_pc4_d;

    logic accept_s;
    logic drain_s;

    // Handshake qualifiers.
    always_comb begin
        accept_s = in_valid && in_ready;
        drain_s  = m_valid_q && out_ready;
    end

    // State register: reset wins over every other update.
    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid_q <= 1'b0;
            m_ir_q    <= {IR_W{1'b0}};
            m_pc4_q   <= RESET_PC4_T;
            s_valid_q <= 1'b0;
            s_ir_q    <= {IR_W{1'b0}};
            s_pc4_q   <= {PC_W{1'b0}};
        end else begin
            m_valid_q <= m_valid_d;
            m_ir_q    <= m_ir_d;
            m_pc4_q   <= m_pc4_d;
            s_valid_q <= s_valid_d;
            s_ir_q    <= s_ir_d;
            s_pc4_q   <= s_pc4_d;
        end
    end

    // Next-state logic: flush squashes everything, else walk the skid FSM.
    always_comb begin
        m_valid_d = m_valid_q;
        m_ir_d    = m_ir_q;
        m_pc4_d   = m_pc4_q;
        s_valid_d = s_valid_q;
        s_ir_d    = s_ir_q;
        s_pc4_d   = s_pc4_q;

        if (flush) begin
            // m_pc4 is deliberately kept so decode still sees the last PC.
            m_valid_d = 1'b0;
            s_valid_d = 1'b0;
            m_ir_d    = {IR_W{1'b0}};
        end else begin
            case ({m_valid_q, s_valid_q})
                ST_EMPTY: begin
                    if (accept_s) begin
                        m_valid_d = 1'b1;
                        m_ir_d    = in_ir;
                        m_pc4_d   = in_pc4;
                    end else begin
                        m_valid_d = 1'b0;
                    end
                end
                ST_ONE: begin
                    if (accept_s && drain_s) begin
                        m_ir_d  = in_ir;
                        m_pc4_d = in_pc4;
                    end else if (accept_s) begin
                        // Decode is stalled: park the new beat behind main.
                        s_valid_d = 1'b1;
                        s_ir_d    = in_ir;
                        s_pc4_d   = in_pc4;
                    end else if (drain_s) begin
                        m_valid_d = 1'b0;
                    end else begin
                        m_valid_d = 1'b1;
                    end
                end
                ST_TWO: begin
                    // in_ready is low here, so only a drain can move us.
                    if (drain_s) begin
                        m_ir_d    = s_ir_q;
                        m_pc4_d   = s_pc4_q;
                        s_valid_d = 1'b0;
                    end else begin
                        s_valid_d = 1'b1;
                    end
                end
                default: begin
                    // Unreachable encoding: drop to EMPTY rather than emit a
                    // beat of unknown provenance.
                    m_valid_d = 1'b0;
                    s_valid_d = 1'b0;
                end
            endcase
        end
    end

    // Outputs: payload comes straight from the main register.
    always_comb begin
        in_ready  = !s_valid_q && !reset;
        out_valid = m_valid_q;
        out_ir    = m_ir_q;
        out_pc4   = m_pc4_q;
    end

`ifdef IF_ID_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Stall counter next value: saturate at all-ones, flush has no effect.
    always_comb begin
        if (m_valid_q && !out_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // Stall counter register, cleared by reset only.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_if_id_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_if_id_skid_reg
//
// Directed bench for if_id_skid_reg with default parameters. Inputs change
// 1 time unit after a rising edge; outputs are sampled there too.
// Expected stall_cnt values depend on IF_ID_STALL_CNT_EN.
// -----------------------------------------------------------------------------
module tb_if_id_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_ir;
    logic [31:0] in_pc4;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_ir;
    logic [31:0] out_pc4;
    logic [15:0] stall_cnt;

    integer checks;
    integer errors;

`ifdef IF_ID_STALL_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    if_id_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ir     (in_ir),
        .in_pc4    (in_pc4),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ir    (out_ir),
        .out_pc4   (out_pc4),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected counter value in this build for a given live count.
    function automatic logic [15:0] exp_cnt(input logic [15:0] live);
        return CNT_EN ? live : 16'h0000;
    endfunction

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_ir = 32'h0; in_pc4 = 32'h0;
        tick();
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_in_ready_low got %b want 0", in_ready);
        end
        tick();
        reset = 1'b0;
        repeat (3) tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_ir !== 32'h0) begin
            errors++; $display("FAIL reset_out_ir got %h want 00000000", out_ir);
        end
        checks++;
        if (out_pc4 !== 32'h4) begin
            errors++; $display("FAIL reset_out_pc4 got %h want 00000004", out_pc4);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        checks++;
        if (stall_cnt !== 16'h0) begin
            errors++; $display("FAIL reset_stall_cnt got %h want 0000", stall_cnt);
        end
    endtask

    task automatic test_stream();
        logic [31:0] ir_e, pc_e;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            ir_e = 32'h2010_0001 + 32'(i);
            pc_e = 32'h0000_3004 + 32'(4 * i);
            in_valid = 1'b1; in_ir = ir_e; in_pc4 = pc_e;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++; $display("FAIL stream_in_ready[%0d] got %b want 1", i, in_ready);
            end
            tick();
            checks++;
            if (out_valid !== 1'b1 || out_ir !== ir_e || out_pc4 !== pc_e) begin
                errors++;
                $display("FAIL stream_beat[%0d] got v=%b ir=%h pc4=%h want v=1 ir=%h pc4=%h",
                         i, out_valid, out_ir, out_pc4, ir_e, pc_e);
            end
        end
        in_valid = 1'b0;
        tick();
        checks++;
        if (out_valid !== 1'b0 || out_ir !== 32'h2010_0005) begin
            errors++;
            $display("FAIL stream_drained got v=%b ir=%h want v=0 ir=20100005", out_valid, out_ir);
        end
    endtask

    task automatic test_back_pressure();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h1111_0000; in_pc4 = 32'h0000_4000;
        tick();                                  // A in main, ONE
        in_ir = 32'h2222_0000; in_pc4 = 32'h0000_4004;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL bp_ready_one got %b want 1", in_ready);
        end
        tick();                                  // B in skid, TWO, stall=1
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_ir !== 32'h1111_0000) begin
            errors++;
            $display("FAIL bp_two got rdy=%b v=%b ir=%h want rdy=0 v=1 ir=11110000",
                     in_ready, out_valid, out_ir);
        end
        // Offer a beat that must be refused while full.
        in_ir = 32'h5555_0000; in_pc4 = 32'h0000_4008;
        tick();                                  // hold TWO, stall=2
        checks++;
        if (in_ready !== 1'b0 || out_ir !== 32'h1111_0000 || out_pc4 !== 32'h4000) begin
            errors++;
            $display("FAIL bp_hold got rdy=%b ir=%h pc4=%h want rdy=0 ir=11110000 pc4=00004000",
                     in_ready, out_ir, out_pc4);
        end
        checks++;
        if (stall_cnt !== exp_cnt(16'd2)) begin
            errors++; $display("FAIL bp_stall_cnt got %h want %h", stall_cnt, exp_cnt(16'd2));
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick();                                  // A drained, B in main
        checks++;
        if (out_valid !== 1'b1 || out_ir !== 32'h2222_0000 || out_pc4 !== 32'h4004 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_second got v=%b ir=%h pc4=%h rdy=%b want v=1 ir=22220000 pc4=00004004 rdy=1",
                     out_valid, out_ir, out_pc4, in_ready);
        end
        tick();                                  // B drained, EMPTY
        checks++;
        if (out_valid !== 1'b0 || out_ir !== 32'h2222_0000) begin
            errors++;
            $display("FAIL bp_empty got v=%b ir=%h want v=0 ir=22220000", out_valid, out_ir);
        end
        checks++;
        if (stall_cnt !== exp_cnt(16'd2)) begin
            errors++; $display("FAIL bp_stall_after got %h want %h", stall_cnt, exp_cnt(16'd2));
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h6000_0001; in_pc4 = 32'h0000_5004;
        tick();                                  // ONE
        in_ir = 32'h6000_0002; in_pc4 = 32'h0000_5008;
        tick();                                  // TWO, stall=3
        in_ir = 32'h3333_0000; in_pc4 = 32'h0000_7000;
        flush = 1'b1;
        tick();                                  // squashed, stall=4
        checks++;
        if (out_valid !== 1'b0 || out_ir !== 32'h0 || out_pc4 !== 32'h5004 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_state got v=%b ir=%h pc4=%h rdy=%b want v=0 ir=00000000 pc4=00005004 rdy=1",
                     out_valid, out_ir, out_pc4, in_ready);
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || out_ir === 32'h3333_0000) begin
                errors++;
                $display("FAIL flush_no_leak[%0d] got v=%b ir=%h want v=0", i, out_valid, out_ir);
            end
        end
        checks++;
        if (stall_cnt !== exp_cnt(16'd4)) begin
            errors++; $display("FAIL flush_keeps_cnt got %h want %h", stall_cnt, exp_cnt(16'd4));
        end
    endtask

    task automatic test_reset_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h7777_0000; in_pc4 = 32'h0000_8000;
        reset = 1'b1; flush = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL rf_in_ready got %b want 0", in_ready);
        end
        tick();
        reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_ir !== 32'h0 || out_pc4 !== 32'h4 || stall_cnt !== 16'h0) begin
            errors++;
            $display("FAIL rf_values got v=%b ir=%h pc4=%h cnt=%h want v=0 ir=00000000 pc4=00000004 cnt=0000",
                     out_valid, out_ir, out_pc4, stall_cnt);
        end
    endtask

    task automatic test_saturation();
        out_ready = 1'b0;
        in_valid = 1'b1; in_ir = 32'h9999_0000; in_pc4 = 32'h0000_9004;
        tick();                                  // beat loaded, count starts next edge
        in_valid = 1'b0;
        repeat (65534) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== exp_cnt(16'hFFFE)) begin
            errors++; $display("FAIL sat_fffe got %h want %h", stall_cnt, exp_cnt(16'hFFFE));
        end
        tick();
        checks++;
        if (stall_cnt !== exp_cnt(16'hFFFF)) begin
            errors++; $display("FAIL sat_ffff got %h want %h", stall_cnt, exp_cnt(16'hFFFF));
        end
        repeat (4465) @(posedge clk);
        #1;
        checks++;
        if (stall_cnt !== exp_cnt(16'hFFFF) || out_valid !== 1'b1 || out_ir !== 32'h9999_0000) begin
            errors++;
            $display("FAIL sat_hold got cnt=%h v=%b ir=%h want cnt=%h v=1 ir=99990000",
                     stall_cnt, out_valid, out_ir, exp_cnt(16'hFFFF));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_stream();
        test_back_pressure();
        test_flush();
        test_reset_flush();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
